// File: rtl/cop0_state_unit.sv
// COP0 architectural state: Status, Cause, EPC, Count/Compare timer, LLAddr and LLbit.
// Applies one execute-stage COP0 op per cycle, samples hardware interrupts
// and raises a registered interrupt request to the pipeline.
module cop0_state_unit #(
    parameter int          HW_INT_NUM   = 5,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0004
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [4:0]            wr_addr,
    input  logic [31:0]           wdata,
    input  logic [31:0]           mem_addr,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic [4:0]            rd_addr,
    output logic [31:0]           rd_data,
    output logic [31:0]           status,
    output logic [31:0]           epc,
    output logic                  llbit,
    output logic                  irq
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MTC0 = 3'd1,
        OP_ERET = 3'd2,
        OP_EI   = 3'd3,
        OP_DI   = 3'd4,
        OP_EXC  = 3'd5,
        OP_LL   = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    localparam logic [4:0]  REG_LLADDR  = 5'd17;

    // Implemented Status bits: IE, EXL, ERL, IM[7:0], BEV
    localparam logic [31:0] STATUS_MASK = 32'h0040_FF07;
    localparam logic [3:0]  PRESC_MAX   = 4'(COUNT_DIV - 1);

    logic [31:0]           r_status;
    logic [1:0]            r_sw_ip;
    logic [HW_INT_NUM-1:0] r_hw_ip;
    logic                  r_timer_ip;
    logic                  r_bd;
    logic [4:0]            r_exc_code;
    logic [31:0]           r_epc;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic [3:0]            r_presc;
    logic [27:0]           r_lladdr;
    logic                  r_llbit;
    logic                  r_irq;

    op_e         w_op;
    logic        w_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_do_exc;
    logic        w_do_ll;
    logic        w_do_eret;
    logic        w_wrap;
    logic        w_match;
    logic [7:0]  w_ip;
    logic [31:0] w_cause;
    logic        w_unused;

    assign w_op         = op_e'(op);
    assign w_mtc0       = op_valid && (w_op == OP_MTC0);
    assign w_wr_count   = w_mtc0 && (wr_addr == REG_COUNT);
    assign w_wr_compare = w_mtc0 && (wr_addr == REG_COMPARE);
    assign w_wr_status  = w_mtc0 && (wr_addr == REG_STATUS);
    assign w_wr_cause   = w_mtc0 && (wr_addr == REG_CAUSE);
    assign w_wr_epc     = w_mtc0 && (wr_addr == REG_EPC);
    assign w_do_exc     = op_valid && (w_op == OP_EXC);
    assign w_do_ll      = op_valid && (w_op == OP_LL);
    assign w_do_eret    = op_valid && (w_op == OP_ERET);

    // LLAddr keeps only the 16-byte line address
    assign w_unused     = ^mem_addr[3:0];

    assign w_wrap  = (r_presc == PRESC_MAX);
    // A Count write in the wrap cycle suppresses the increment, hence also the match
    assign w_match = w_wrap && !w_wr_count && ((r_count + 32'd1) == r_compare);

    // Assemble Cause.IP: software bits, sampled hardware lines, timer in IP7
    always_comb begin
        w_ip      = '0;
        w_ip[1:0] = r_sw_ip;
        for (int unsigned i = 0; i < unsigned'(HW_INT_NUM); i++) begin
            w_ip[2+i] = r_hw_ip[i];
        end
        w_ip[7]   = r_timer_ip;
        w_cause   = {r_bd, 15'b0, w_ip, 1'b0, r_exc_code, 2'b00};
    end

    // Status updates from MTC0, ERET, EI/DI and exception entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= RESET_STATUS & STATUS_MASK;
        end else if (op_valid) begin
            case (w_op)
                OP_MTC0: if (w_wr_status) r_status <= wdata & STATUS_MASK;
                OP_ERET: begin
                    if (r_status[2]) r_status[2] <= 1'b0;
                    else             r_status[1] <= 1'b0;
                end
                OP_EI:   r_status[0] <= 1'b1;
                OP_DI:   r_status[0] <= 1'b0;
                OP_EXC:  r_status[1] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Cause software bits, BD/ExcCode and EPC
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_ip    <= '0;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            if (w_wr_cause) r_sw_ip <= wdata[9:8];
            if (w_wr_epc)   r_epc   <= wdata;
            if (w_do_exc) begin
                if (!r_status[1]) begin
                    r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                    r_bd  <= exc_bd;
                end
                r_exc_code <= exc_code;
            end
        end
    end

    // Prescaled Count, Compare and the sticky timer pending bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_timer_ip <= 1'b0;
        end else begin
            if (w_wr_count) begin
                r_count <= wdata;
                r_presc <= w_wrap ? '0 : r_presc + 4'd1;
            end else if (w_wrap) begin
                r_count <= r_count + 32'd1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 4'd1;
            end
            if (w_wr_compare) r_compare <= wdata;
            if (w_wr_compare)  r_timer_ip <= 1'b0;
            else if (w_match)  r_timer_ip <= 1'b1;
        end
    end

    // Single-stage sample of the level-sensitive hardware interrupt lines
    always_ff @(posedge clk) begin
        if (reset) r_hw_ip <= '0;
        else       r_hw_ip <= hw_int;
    end

    // Registered interrupt request from the current enable/mask/pending state
    always_ff @(posedge clk) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= r_status[0] && !r_status[1] && !r_status[2] && (|(w_ip & r_status[15:8]));
    end

    // Load-linked address and link bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lladdr <= '0;
            r_llbit  <= 1'b0;
        end else if (w_do_ll) begin
            r_lladdr <= mem_addr[31:4];
            r_llbit  <= 1'b1;
        end else if (w_do_eret) begin
            r_llbit  <= 1'b0;
        end
    end

    // MFC0 read mux, no write bypass
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_COUNT:   rd_data = r_count;
            REG_COMPARE: rd_data = r_compare;
            REG_STATUS:  rd_data = r_status;
            REG_CAUSE:   rd_data = w_cause;
            REG_EPC:     rd_data = r_epc;
            REG_LLADDR:  rd_data = {4'b0, r_lladdr};
            default:     rd_data = '0;
        endcase
    end

    assign status = r_status;
    assign epc    = r_epc;
    assign llbit  = r_llbit;
    assign irq    = r_irq;

endmodule
